// File: rtl/mp_addsub_seq.sv
// Byte-serial multi-precision add/subtract sequencer: one 8-bit adder slice
// is driven once per clock, LSB first, with the carry chained between cycles.
module mp_addsub_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 sub_i,
  input  logic [8*WORDS-1:0]   a_i,
  input  logic [8*WORDS-1:0]   b_i,
  input  logic                 abort_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [8*WORDS-1:0]   result_o,
  output logic                 carry_o,
  output logic                 overflow_o,
  output logic                 zero_o
);

  localparam int unsigned N  = 8 * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic [KW-1:0] k_q, k_d;
  logic          cy_q, cy_d;
  logic          zacc_q, zacc_d;
  logic [N-1:0]  res_q, res_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic [7:0] in1, in2, sum;
  logic [7:0] low7;
  logic       cout, slice_ovf;

  // Byte select by compare against constant indices keeps every slice in range.
  always_comb begin
    in1 = '0;
    in2 = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (k_q == KW'(i)) begin
        in1 = a_q[8*i +: 8];
        in2 = b_q[8*i +: 8];
      end
    end
    in2 = in2 ^ {8{sub_q}};
  end

  // 8-bit slice; overflow is carry into bit 7 xor carry out of bit 7.
  always_comb begin
    {cout, sum} = {1'b0, in1} + {1'b0, in2} + {8'b0, cy_q};
    low7        = {1'b0, in1[6:0]} + {1'b0, in2[6:0]} + {7'b0, cy_q};
    slice_ovf   = low7[7] ^ cout;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    k_d     = k_q;
    cy_d    = cy_q;
    zacc_d  = zacc_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          k_d     = '0;
          zacc_d  = 1'b0;
          cy_d    = sub_i;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (k_q == KW'(i)) res_d[8*i +: 8] = sum;
          end
          cy_d   = cout;
          zacc_d = zacc_q | (|sum);
          if (k_q == K_LAST) begin
            cout_d  = cout;
            ovf_d   = slice_ovf;
            zero_d  = ~(zacc_q | (|sum));
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
      zacc_q  <= zacc_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign result_o   = res_q;
  assign carry_o    = cout_q;
  assign overflow_o = ovf_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Randomized self-checking bench: a cycle-count + arithmetic model predicts
// ready/done and the full-width result, checked every falling edge.
module tb_mp_addsub_seq;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, abort = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        rdy, done, cy, ov, zr;
  logic [31:0] res;

  logic        start1 = 1'b0, sub1 = 1'b0, abort1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        rdy1, done1, cy1, ov1, zr1;
  logic [7:0]  res1;

  mp_addsub_seq #(.WORDS(W)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
    .abort_i(abort), .ready_o(rdy), .done_o(done), .result_o(res),
    .carry_o(cy), .overflow_o(ov), .zero_o(zr)
  );

  mp_addsub_seq #(.WORDS(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .sub_i(sub1), .a_i(a1), .b_i(b1),
    .abort_i(abort1), .ready_o(rdy1), .done_o(done1), .result_o(res1),
    .carry_o(cy1), .overflow_o(ov1), .zero_o(zr1)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Two's-complement arithmetic on an nb-byte word.
  function automatic void ref_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                                 input int unsigned nb, output logic [31:0] r,
                                 output logic c, output logic v, output logic z);
    logic [63:0] mask, full, bb;
    int unsigned n, sb;
    n    = 8 * nb;
    sb   = n - 1;
    mask = (64'd1 << n) - 64'd1;
    bb   = (s ? ~{32'd0, bv} : {32'd0, bv}) & mask;
    full = ({32'd0, av} & mask) + bb + {63'd0, s};
    r    = full[31:0] & mask[31:0];
    c    = full[n];
    v    = s ? (av[sb] != bv[sb] && r[sb] != av[sb])
             : (av[sb] == bv[sb] && r[sb] != av[sb]);
    z    = (r == 32'd0);
  endfunction

  // m_cnt: 0 idle, W+1..2 running, 1 done cycle.
  int          m_cnt  = 0;
  bit          m_have = 1'b1;
  logic [31:0] m_r = '0, p_r = '0;
  logic        m_c = 1'b0, m_v = 1'b0, m_z = 1'b0;
  logic        p_c = 1'b0, p_v = 1'b0, p_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_have = 1'b1;
      m_r = '0; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
    end else if (m_cnt > 0) begin
      if (abort && m_cnt >= 2) begin
        m_cnt = 0; m_have = 1'b0;
      end else begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_r = p_r; m_c = p_c; m_v = p_v; m_z = p_z; m_have = 1'b1;
        end
      end
    end else if (start) begin
      ref_op(a, b, sub, W, p_r, p_c, p_v, p_z);
      m_cnt  = W + 1;
      m_have = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready", rdy, m_cnt == 0);
    chk("done", done, m_cnt == 1);
    if (m_have) begin
      chk("result", res, m_r);
      chk("carry", cy, m_c);
      chk("overflow", ov, m_v);
      chk("zero", zr, m_z);
    end
  end

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s);
    @(negedge clk); #1;
    start = 1'b1; a = av; b = bv; sub = s;
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = ~s;
    repeat (W + 1) @(negedge clk);
  endtask

  task automatic run1(input logic [7:0] av, input logic [7:0] bv, input logic s);
    logic [31:0] r; logic c, v, z; int lat; bit seen;
    ref_op({24'd0, av}, {24'd0, bv}, s, 1, r, c, v, z);
    @(negedge clk); #1;
    start1 = 1'b1; a1 = av; b1 = bv; sub1 = s;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1'b1; lat = i;
        chk("w1_result", res1, r[7:0]);
        chk("w1_carry", cy1, c);
        chk("w1_overflow", ov1, v);
        chk("w1_zero", zr1, z);
      end
      if (i == 1) begin #1; start1 = 1'b0; end
    end
    chk("w1_latency", lat, 2);
    @(negedge clk);
    chk("w1_ready", rdy1, 1'b1);
  endtask

  initial begin
    logic [31:0] r; logic c, v, z; int lat; bit seen;

    // Model pinned against hand-computed values.
    ref_op(32'h12345678, 32'h11111111, 1'b0, 4, r, c, v, z);
    chk("pin_add", {r, c, v, z}, {32'h23456789, 3'b000});
    ref_op(32'h80000000, 32'h00000001, 1'b1, 4, r, c, v, z);
    chk("pin_sub_ovf", {r, c, v, z}, {32'h7FFFFFFF, 3'b110});
    ref_op(32'h00000000, 32'h00000001, 1'b1, 4, r, c, v, z);
    chk("pin_sub_borrow", {r, c, v, z}, {32'hFFFFFFFF, 3'b000});
    ref_op(32'h00000080, 32'h00000080, 1'b0, 1, r, c, v, z);
    chk("pin_w1", {r, c, v, z}, {32'h00000000, 3'b111});

    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // First op: explicit latency and literal result.
    @(negedge clk); #1;
    start = 1'b1; a = 32'h12345678; b = 32'h11111111; sub = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; lat = i;
        chk("lit_result", res, 32'h23456789);
      end
      if (i == 1) begin #1; start = 1'b0; a = '0; b = '0; end
    end
    chk("latency", lat, W + 1);

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    chk("lit_zero", {res, cy, zr}, {32'h0, 2'b11});
    run_op(32'h00000005, 32'h00000005, 1'b1);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    chk("lit_ovf", {res, cy, ov}, {32'h80000000, 2'b01});
    run_op(32'h80000000, 32'h00000001, 1'b1);
    run_op(32'h00000000, 32'h00000001, 1'b1);

    // Start pulses during RUN and DONE are ignored.
    @(negedge clk); #1;
    start = 1'b1; a = 32'h01020304; b = 32'h10203040; sub = 1'b0;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk); #1 begin start = 1'b1; a = 32'hDEADBEEF; b = 32'h0BADF00D; sub = 1'b1; end
    @(negedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    chk("busy_ignored", res, 32'h11223344);
    repeat (3) @(negedge clk);

    // Start held high: acceptance every W+2 cycles.
    @(negedge clk); #1 start = 1'b1;
    repeat (30) begin
      @(negedge clk); #1;
      a = $urandom; b = $urandom; sub = 1'($urandom);
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Abort during byte 2, then a clean operation.
    @(negedge clk); #1;
    start = 1'b1; a = 32'hAAAAAAAA; b = 32'h55555555; sub = 1'b0;
    @(negedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #1 abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    chk("abort_ready", rdy, 1'b1);
    run_op(32'h0000FFFF, 32'h00000001, 1'b0);

    // Asynchronous reset mid-RUN.
    @(negedge clk); #1;
    start = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0; sub = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", rdy, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_result", res, 32'h0);
    chk("rst_flags", {cy, ov, zr}, 3'b000);
    @(negedge clk); #1 rst_n = 1'b1;
    run_op(32'h00000005, 32'h00000005, 1'b1);

    // Randomized traffic with occasional aborts and corner operands.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      sub   = 1'($urandom);
      abort = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'h7FFFFFFF;
        2:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = 32'h00000001;
        default: b = $urandom;
      endcase
    end
    #0 begin start = 1'b0; abort = 1'b0; end
    repeat (W + 3) @(negedge clk);

    // Single-byte instance.
    run1(8'h80, 8'h80, 1'b0);
    chk("w1_lit", {res1, cy1, ov1, zr1}, {8'h00, 3'b111});
    for (int i = 0; i < 20; i++) run1(8'($urandom), 8'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
